vga_pattern_gen: RTL and testbench

Pixel-source stage directly downstream of the VGA sync generator. Consumes the sync generator's pixel coordinates, blank flag and HS/VS pulses. Produces RGB 3:3:2 colour for one of four selectable test patterns, with sync and blank delayed to stay aligned with the colour pipeline. Holds per-frame state (frame counter, bouncing box position, latched mode) updated once per frame, so patterns animate without tearing.

---
 rtl/vga_pattern_gen_pkg.sv | 42 ++++
 rtl/vga_pattern_gen_if.sv | 29 ++
 rtl/vga_box_motion.sv | 79 +++++++
 rtl/vga_pattern_gen.sv | 139 +++++++++++++
 tb/tb_vga_pattern_gen.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pattern_gen_pkg.sv
// Shared constants, mode encodings and RGB332 payload type for the VGA pattern source.
package vga_pattern_gen_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_BOX_SIZE = 32;

  localparam int unsigned X_W     = 11;
  localparam int unsigned Y_W     = 10;
  localparam int unsigned BX_W    = 10;
  localparam int unsigned BY_W    = 9;
  localparam int unsigned FRAME_W = 8;
  localparam int unsigned BAR_W   = 80;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  typedef struct packed {
    logic [2:0] red;
    logic [2:0] grn;
    logic [1:0] blu;
  } rgb332_t;

  localparam rgb332_t RGB_WHITE  = '{red: 3'd7, grn: 3'd7, blu: 2'd3};
  localparam rgb332_t RGB_BLACK  = '{red: 3'd0, grn: 3'd0, blu: 2'd0};
  localparam rgb332_t RGB_BOX_BG = '{red: 3'd0, grn: 3'd0, blu: 2'd1};

  // Colour-bar index from a compare chain; columns are BAR_W pixels wide.
  function automatic logic [2:0] bar_index(input logic [X_W-1:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (x >= X_W'(i * BAR_W)) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel bus between the sync generator side (master) and the pattern source (slave).
interface vga_pattern_gen_if;
  import vga_pattern_gen_pkg::*;

  logic signed [X_W-1:0]     X;
  logic        [Y_W-1:0]     Y;
  logic                      BLANK;
  logic                      HS;
  logic                      VS;
  logic        [1:0]         MODE;
  logic        [2:0]         RED;
  logic        [2:0]         GRN;
  logic        [1:0]         BLU;
  logic                      HS_O;
  logic                      VS_O;
  logic                      BLANK_O;
  logic        [FRAME_W-1:0] FRAME;

  modport master (
    output X, Y, BLANK, HS, VS, MODE,
    input  RED, GRN, BLU, HS_O, VS_O, BLANK_O, FRAME
  );

  modport slave (
    input  X, Y, BLANK, HS, VS, MODE,
    output RED, GRN, BLU, HS_O, VS_O, BLANK_O, FRAME
  );

endinterface

// File: rtl/vga_box_motion.sv
// Bouncing-box position and direction registers, stepped once per frame tick.
module vga_box_motion
  import vga_pattern_gen_pkg::*;
#(
  parameter int unsigned BOX_SIZE = DEF_BOX_SIZE,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            TICK,
  output logic [BX_W-1:0] BOX_X,
  output logic [BY_W-1:0] BOX_Y
);

  localparam logic [BX_W-1:0] X_MAX = BX_W'(H_ACTIVE - BOX_SIZE);
  localparam logic [BY_W-1:0] Y_MAX = BY_W'(V_ACTIVE - BOX_SIZE);

  logic            dir_x, dir_y;
  logic            dir_x_n, dir_y_n;
  logic [BX_W-1:0] box_x_n;
  logic [BY_W-1:0] box_y_n;

  always_ff @(posedge CLK) begin
    if (RST) begin
      BOX_X <= '0;
      BOX_Y <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else begin
      BOX_X <= box_x_n;
      BOX_Y <= box_y_n;
      dir_x <= dir_x_n;
      dir_y <= dir_y_n;
    end
  end

  // An outward step at a limit becomes an inward step with the direction flipped.
  always_comb begin
    box_x_n = BOX_X;
    box_y_n = BOX_Y;
    dir_x_n = dir_x;
    dir_y_n = dir_y;
    if (TICK) begin
      if (dir_x) begin
        if (BOX_X == X_MAX) begin
          dir_x_n = 1'b0;
          box_x_n = BOX_X - BX_W'(1);
        end else begin
          box_x_n = BOX_X + BX_W'(1);
        end
      end else begin
        if (BOX_X == '0) begin
          dir_x_n = 1'b1;
          box_x_n = BX_W'(1);
        end else begin
          box_x_n = BOX_X - BX_W'(1);
        end
      end

      if (dir_y) begin
        if (BOX_Y == Y_MAX) begin
          dir_y_n = 1'b0;
          box_y_n = BOX_Y - BY_W'(1);
        end else begin
          box_y_n = BOX_Y + BY_W'(1);
        end
      end else begin
        if (BOX_Y == '0) begin
          dir_y_n = 1'b1;
          box_y_n = BY_W'(1);
        end else begin
          box_y_n = BOX_Y - BY_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Four-mode RGB332 test-pattern source with a two-stage colour pipeline and
// per-frame state (frame counter, mode latch, bouncing box) updated on VS fall.
module vga_pattern_gen
  import vga_pattern_gen_pkg::*;
#(
  parameter int unsigned BOX_SIZE = DEF_BOX_SIZE,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic              CLK,
  input  logic              RST,
  vga_pattern_gen_if.slave  bus
);

  // Frame-rate state
  logic               vs_q;
  logic               tick_c;
  logic [FRAME_W-1:0] frame_q;
  mode_e              mode_q;
  logic [BX_W-1:0]    box_x;
  logic [BY_W-1:0]    box_y;

  // Stage-1 results
  logic        vis1, hs1, vs1;
  mode_e       mode1;
  logic [2:0]  bar1;
  logic        chk1;
  logic        box1;
  logic [2:0]  grad_r1, grad_g1;
  logic [1:0]  grad_b1;

  // Stage-1 combinational terms
  logic [X_W-1:0] x_u;
  logic [X_W-1:0] y_u;
  logic [X_W-1:0] bx_u, by_u;
  logic [9:0]     chk_sum_c;
  logic           vis_c;
  logic           in_box_c;
  rgb332_t        rgb_c;

  assign tick_c = vs_q & ~bus.VS;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vs_q    <= 1'b1;
      frame_q <= '0;
      mode_q  <= MODE_BARS;
    end else begin
      vs_q <= bus.VS;
      if (tick_c) begin
        frame_q <= frame_q + FRAME_W'(1);
        mode_q  <= mode_e'(bus.MODE);
      end
    end
  end

  assign bus.FRAME = frame_q;

  vga_box_motion #(
    .BOX_SIZE (BOX_SIZE),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_box_motion (
    .CLK   (CLK),
    .RST   (RST),
    .TICK  (tick_c),
    .BOX_X (box_x),
    .BOX_Y (box_y)
  );

  // Negative X has bit 10 set, so one unsigned compare rejects it along with X >= H_ACTIVE.
  assign x_u       = bus.X;
  assign y_u       = {1'b0, bus.Y};
  assign bx_u      = {1'b0, box_x};
  assign by_u      = {2'b00, box_y};
  assign vis_c     = ~bus.BLANK && (x_u < X_W'(H_ACTIVE)) && (bus.Y < Y_W'(V_ACTIVE));
  assign chk_sum_c = x_u[9:0] + 10'(frame_q);
  assign in_box_c  = (x_u >= bx_u) && (x_u < bx_u + X_W'(BOX_SIZE)) &&
                     (y_u >= by_u) && (y_u < by_u + X_W'(BOX_SIZE));

  always_ff @(posedge CLK) begin
    if (RST) begin
      vis1    <= 1'b0;
      hs1     <= 1'b1;
      vs1     <= 1'b1;
      mode1   <= MODE_BARS;
      bar1    <= '0;
      chk1    <= 1'b0;
      box1    <= 1'b0;
      grad_r1 <= '0;
      grad_g1 <= '0;
      grad_b1 <= '0;
    end else begin
      vis1    <= vis_c;
      hs1     <= bus.HS;
      vs1     <= bus.VS;
      mode1   <= mode_q;
      bar1    <= bar_index(x_u);
      chk1    <= chk_sum_c[5] ^ bus.Y[5];
      box1    <= in_box_c;
      grad_r1 <= x_u[9:7];
      grad_g1 <= bus.Y[8:6];
      grad_b1 <= frame_q[5:4];
    end
  end

  // Colour select from stage-1 state only; anything off-screen is black.
  always_comb begin
    rgb_c = RGB_BLACK;
    if (vis1) begin
      case (mode1)
        MODE_BARS:  rgb_c = '{red: {3{bar1[2]}}, grn: {3{bar1[1]}}, blu: {2{bar1[0]}}};
        MODE_CHECK: rgb_c = chk1 ? RGB_WHITE : RGB_BLACK;
        MODE_GRAD:  rgb_c = '{red: grad_r1, grn: grad_g1, blu: grad_b1};
        MODE_BOX:   rgb_c = box1 ? RGB_WHITE : RGB_BOX_BG;
        default:    rgb_c = RGB_BLACK;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.RED     <= '0;
      bus.GRN     <= '0;
      bus.BLU     <= '0;
      bus.HS_O    <= 1'b1;
      bus.VS_O    <= 1'b1;
      bus.BLANK_O <= 1'b1;
    end else begin
      bus.RED     <= rgb_c.red;
      bus.GRN     <= rgb_c.grn;
      bus.BLU     <= rgb_c.blu;
      bus.HS_O    <= hs1;
      bus.VS_O    <= vs1;
      bus.BLANK_O <= ~vis1;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: per-cycle compare against a frame-level
// behavioural model plus hand-computed pixel expectations.
module tb_vga_pattern_gen;

  logic clk;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  vga_pattern_gen_if bus();

  vga_pattern_gen dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
    logic       blank;
  } exp_t;

  int   m_frame, m_mode, m_bx, m_by, m_dx, m_dy;
  bit   m_vsq;
  bit   armed = 1'b0;
  exp_t p1, p2;

  function automatic logic [7:0] rgb8(input int r, input int g, input int b);
    return 8'(r * 32 + g * 4 + b);
  endfunction

  function automatic logic [7:0] model_rgb(input int x, input int y, input bit blank,
                                           input int mode, input int frame,
                                           input int bx, input int by);
    int i, s;
    if (blank || x < 0 || x >= 640 || y >= 480) return 8'h00;
    case (mode)
      0: begin
        i = x / 80;
        return rgb8(((i >> 2) & 1) * 7, ((i >> 1) & 1) * 7, (i & 1) * 3);
      end
      1: begin
        s = (x + frame) % 1024;
        return ((((s >> 5) & 1) ^ ((y >> 5) & 1)) != 0) ? 8'hFF : 8'h00;
      end
      2: return rgb8((x >> 7) & 7, (y >> 6) & 7, (frame >> 4) & 3);
      default: begin
        if (x >= bx && x < bx + 32 && y >= by && y < by + 32) return 8'hFF;
        return 8'h01;
      end
    endcase
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.rgb = 8'h00; e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b1;
    return e;
  endfunction

  always @(posedge clk) begin
    int x, y;
    exp_t e;
    if (rst) begin
      m_frame = 0; m_mode = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
      m_vsq = 1'b1;
      p1 = idle_exp();
      p2 = idle_exp();
      armed = 1'b1;
    end else begin
      x = $signed(bus.X);
      y = int'(bus.Y);
      e.rgb   = model_rgb(x, y, bus.BLANK, m_mode, m_frame, m_bx, m_by);
      e.hs    = bus.HS;
      e.vs    = bus.VS;
      e.blank = !(!bus.BLANK && x >= 0 && x < 640 && y < 480);
      p2 = p1;
      p1 = e;
      if (m_vsq && !bus.VS) begin
        m_frame = (m_frame + 1) % 256;
        m_mode  = int'(bus.MODE);
        if (m_dx > 0 && m_bx == 608)  begin m_dx = -1; m_bx = 607; end
        else if (m_dx < 0 && m_bx == 0) begin m_dx = 1; m_bx = 1; end
        else m_bx = m_bx + m_dx;
        if (m_dy > 0 && m_by == 448)  begin m_dy = -1; m_by = 447; end
        else if (m_dy < 0 && m_by == 0) begin m_dy = 1; m_by = 1; end
        else m_by = m_by + m_dy;
      end
      m_vsq = bus.VS;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (armed) begin
      n_total++;
      if ({bus.RED, bus.GRN, bus.BLU} === p2.rgb && bus.HS_O === p2.hs &&
          bus.VS_O === p2.vs && bus.BLANK_O === p2.blank && bus.FRAME === 8'(m_frame)) begin
        n_pass++;
      end else begin
        $display("FAIL model_cmp t=%0t: rgb=%h hs=%b vs=%b blank=%b frame=%0d, required rgb=%h hs=%b vs=%b blank=%b frame=%0d",
                 $time, {bus.RED, bus.GRN, bus.BLU}, bus.HS_O, bus.VS_O, bus.BLANK_O, bus.FRAME,
                 p2.rgb, p2.hs, p2.vs, p2.blank, m_frame);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input int got, input int expv);
    n_total++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_px(input int x, input int y, input bit blank);
    bus.X     = 11'(x);
    bus.Y     = 10'(y);
    bus.BLANK = blank;
  endtask

  // Drive one pixel, wait the two-cycle latency, then check colour and blank.
  task automatic expect_px(input string name, input int x, input int y, input bit blank,
                           input logic [7:0] exp_rgb, input bit exp_blank);
    drive_px(x, y, blank);
    step();
    step();
    @(negedge clk);
    chk({name, " rgb"}, int'({bus.RED, bus.GRN, bus.BLU}), int'(exp_rgb));
    chk({name, " blank_o"}, int'(bus.BLANK_O), int'(exp_blank));
    step();
  endtask

  task automatic vs_pulse();
    bus.VS = 1'b0;
    step();
    bus.VS = 1'b1;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic sweep_line(input int y);
    for (int x = -8; x <= 648; x++) begin
      drive_px(x, y, 1'b0);
      step();
    end
    drive_px(0, y, 1'b1);
    step();
  endtask

  // 41-cycle low pulse on one of HS/VS/BLANK (sel 0/1/2); checks width and 2-cycle offset.
  task automatic align_pulse(input int sel, input string name);
    int first, cnt;
    bit o;
    first = -1;
    cnt   = 0;
    for (int j = 0; j < 50; j++) begin
      case (sel)
        0: bus.HS = (j < 41) ? 1'b0 : 1'b1;
        1: bus.VS = (j < 41) ? 1'b0 : 1'b1;
        default: bus.BLANK = (j < 41) ? 1'b1 : 1'b0;
      endcase
      @(negedge clk);
      case (sel)
        0: o = !bus.HS_O;
        1: o = !bus.VS_O;
        default: o = bus.BLANK_O;
      endcase
      if (o) begin
        cnt++;
        if (first < 0) first = j;
      end
      step();
    end
    chk({name, " width"}, cnt, 41);
    chk({name, " start"}, first, 2);
  endtask

  // Hard bound on the whole run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, required completion before 2000000");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    bus.X = 11'd100; bus.Y = 10'd10; bus.BLANK = 1'b0;
    bus.HS = 1'b1; bus.VS = 1'b1; bus.MODE = 2'd0;

    // Reset held three cycles mid-line.
    step(); step(); step();
    @(negedge clk);
    chk("reset rgb", int'({bus.RED, bus.GRN, bus.BLU}), 0);
    chk("reset hs_o", int'(bus.HS_O), 1);
    chk("reset vs_o", int'(bus.VS_O), 1);
    chk("reset blank_o", int'(bus.BLANK_O), 1);
    chk("reset frame", int'(bus.FRAME), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("release +1 rgb", int'({bus.RED, bus.GRN, bus.BLU}), 0);
    step();
    @(negedge clk);
    chk("release +2 rgb", int'({bus.RED, bus.GRN, bus.BLU}), 8'h03);
    step();

    // Colour bars and visibility edges.
    expect_px("bars x0",   0,   10, 1'b0, 8'h00, 1'b0);
    expect_px("bars x79",  79,  10, 1'b0, 8'h00, 1'b0);
    expect_px("bars x80",  80,  10, 1'b0, 8'h03, 1'b0);
    expect_px("bars x639", 639, 10, 1'b0, 8'hFF, 1'b0);
    expect_px("bars x640", 640, 10, 1'b0, 8'h00, 1'b1);
    expect_px("bars xneg", -1,  10, 1'b0, 8'h00, 1'b1);
    expect_px("bars y480", 300, 480, 1'b0, 8'h00, 1'b1);
    sweep_line(10);

    // Sync/blank alignment.
    drive_px(100, 10, 1'b0);
    align_pulse(0, "hs align");
    align_pulse(2, "blank align");

    // Mode latch only at the frame tick.
    bus.MODE = 2'd2;
    expect_px("latch hold", 80, 10, 1'b0, 8'h03, 1'b0);
    vs_pulse();
    @(negedge clk);
    chk("latch frame", int'(bus.FRAME), 1);
    step();
    expect_px("grad x128 y64", 128, 64, 1'b0, 8'h24, 1'b0);
    sweep_line(200);
    drive_px(100, 10, 1'b0);
    align_pulse(1, "vs align");

    // Scrolling checker and frame wrap.
    do_reset();
    bus.MODE = 2'd1;
    repeat (31) vs_pulse();
    expect_px("check f31", 0, 32, 1'b0, 8'hFF, 1'b0);
    vs_pulse();
    expect_px("check f32", 0, 32, 1'b0, 8'h00, 1'b0);
    sweep_line(40);
    repeat (224) vs_pulse();
    @(negedge clk);
    chk("frame wrap", int'(bus.FRAME), 0);
    step();

    // Bouncing box.
    do_reset();
    bus.MODE = 2'd3;
    drive_px(0, 0, 1'b1);
    repeat (448) vs_pulse();
    expect_px("box t448 in",  448, 448, 1'b0, 8'hFF, 1'b0);
    expect_px("box t448 out", 448, 447, 1'b0, 8'h01, 1'b0);
    vs_pulse();
    expect_px("box t449 in",  449, 447, 1'b0, 8'hFF, 1'b0);
    expect_px("box t449 out", 449, 479, 1'b0, 8'h01, 1'b0);
    repeat (159) vs_pulse();
    expect_px("box t608 left",  607, 300, 1'b0, 8'h01, 1'b0);
    expect_px("box t608 x608",  608, 300, 1'b0, 8'hFF, 1'b0);
    expect_px("box t608 x639",  639, 300, 1'b0, 8'hFF, 1'b0);
    vs_pulse();
    expect_px("box t609 x607",  607, 300, 1'b0, 8'hFF, 1'b0);
    expect_px("box t609 x639",  639, 300, 1'b0, 8'h01, 1'b0);
    expect_px("box t609 y287",  607, 287, 1'b0, 8'hFF, 1'b0);
    expect_px("box t609 y319",  607, 319, 1'b0, 8'h01, 1'b0);
    sweep_line(300);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
